// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if.sv
// Request/response bundle shared by the fetch bus, the data bus and the
// memory side of mem_arbiter. The package holds the two payload types.
//   req : mem_in_type  -- request travelling toward memory
//          (mem_valid, mem_fence, mem_instr, mem_addr, mem_wdata, mem_wstrb)
//   rsp : mem_out_type -- response travelling back (mem_rdata, mem_ready)
// Modports:
//   master : issues requests (drives req, receives rsp)
//   slave  : serves requests (receives req, drives rsp)
//
// Handshake: req.mem_valid is a single-cycle pulse and the other req fields
// are meaningful only in that cycle. A requester keeps at most one request
// outstanding. rsp.mem_ready pulses for one cycle when the transaction ends,
// and rsp.mem_rdata is valid in that same cycle.
`timescale 1ns/1ps

package mem_arbiter_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_type;
endpackage

interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  mem_in_type  req;
  mem_out_type rsp;

  modport master (output req, input  rsp);
  modport slave  (input  req, output rsp);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter.sv
// Shares one memory port between the instruction-fetch requester (ibus) and
// the data requester (dbus). Each requester has a one-entry pending latch so
// a single-cycle valid pulse is never lost while the port is busy. Conflicts
// are resolved by round-robin or by fixed priority with dbus winning.
// The response goes back to the owner of the in-flight transaction.
//
// Ports:
//   clock       : system clock, all state changes on the rising edge
//   reset       : synchronous, active-high
//   ibus        : slave  -- fetch request in (ibus.req), fetch response out
//   dbus        : slave  -- data request in (dbus.req), data response out
//   mem         : master -- request to memory (mem.req), memory response in
//   timeout_err : one-cycle watchdog abort pulse
//   state_o     : current FSM state (0 idle, 1 busy ibus, 2 busy dbus)
//
// Parameters:
//   round_robin    : 1 = alternate on conflict, 0 = dbus always wins
//   timeout_cycles : watchdog limit, used only when MEM_ARB_TIMEOUT_EN is defined
//
// Build option MEM_ARB_TIMEOUT_EN: adds the watchdog that aborts a transaction
// after timeout_cycles busy cycles without mem_ready. Without it the arbiter
// waits indefinitely and timeout_err stays 0.
`timescale 1ns/1ps

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit          round_robin    = 1'b1,
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  ibus,
  mem_arbiter_if.slave  dbus,
  mem_arbiter_if.master mem,
  output logic          timeout_err,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       pend_i_q, pend_d_q;
  mem_in_type lat_i_q, lat_d_q;
  logic       last_d_q;          // 1 = last launch went to dbus
  mem_in_type mem_req_q;

  logic       req_i, req_d, pick_d, busy, free, launch, timeout_fire;
  mem_in_type cur_i, cur_d, launch_req;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(timeout_cycles - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (launch) begin
      cnt_q <= '0;
    end else if (busy && !mem.rsp.mem_ready) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign timeout_fire = busy & ~mem.rsp.mem_ready & (cnt_q == CNT_LAST);
`else
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    req_i  = pend_i_q | ibus.req.mem_valid;
    req_d  = pend_d_q | dbus.req.mem_valid;
    // A live pulse takes precedence over the latch (it is the newer request).
    cur_i  = ibus.req.mem_valid ? ibus.req : lat_i_q;
    cur_d  = dbus.req.mem_valid ? dbus.req : lat_d_q;
    // dbus wins if it is alone, under fixed priority, or when ibus went last.
    pick_d = req_d & (~req_i | ~round_robin | ~last_d_q);
    busy   = (state_q != ST_IDLE);
    // The port can take a new request when idle or in the completion cycle.
    free   = ~busy | mem.rsp.mem_ready;
    launch = free & (req_i | req_d);

    launch_req           = pick_d ? cur_d : cur_i;
    launch_req.mem_valid = 1'b1;
    launch_req.mem_instr = ~pick_d;

    state_d = state_q;
    if (launch) begin
      state_d = pick_d ? ST_BUSY_D : ST_BUSY_I;
    end else if (free || timeout_fire) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pend_i_q  <= 1'b0;
      pend_d_q  <= 1'b0;
      lat_i_q   <= '0;
      lat_d_q   <= '0;
      last_d_q  <= 1'b0;
      mem_req_q <= '0;
    end else begin
      state_q <= state_d;

      // Fields stay put after launch; only the valid strobe drops.
      if (launch) begin
        mem_req_q <= launch_req;
        last_d_q  <= pick_d;
      end else begin
        mem_req_q.mem_valid <= 1'b0;
      end

      if (ibus.req.mem_valid) lat_i_q <= ibus.req;
      if (dbus.req.mem_valid) lat_d_q <= dbus.req;

      if (launch && !pick_d)       pend_i_q <= 1'b0;
      else if (ibus.req.mem_valid) pend_i_q <= 1'b1;

      if (launch && pick_d)        pend_d_q <= 1'b0;
      else if (dbus.req.mem_valid) pend_d_q <= 1'b1;
    end
  end

  // Response routing. Gated by reset so a ready coinciding with reset is
  // never delivered; a watchdog abort hands the owner ready with zero data.
  always_comb begin
    ibus.rsp = '0;
    dbus.rsp = '0;
    if (!reset && state_q == ST_BUSY_I) begin
      ibus.rsp.mem_ready = mem.rsp.mem_ready | timeout_fire;
      ibus.rsp.mem_rdata = timeout_fire ? 32'h0 : mem.rsp.mem_rdata;
    end
    if (!reset && state_q == ST_BUSY_D) begin
      dbus.rsp.mem_ready = mem.rsp.mem_ready | timeout_fire;
      dbus.rsp.mem_rdata = timeout_fire ? 32'h0 : mem.rsp.mem_rdata;
    end
  end

  assign mem.req     = mem_req_q;
  assign timeout_err = timeout_fire & ~reset;
  assign state_o     = state_q;

  a_timeout_param: assert property (@(posedge clock) timeout_cycles >= 1);
  // A second valid while one is still pending overwrites the latch.
  a_ibus_overrun: assert property (@(posedge clock) disable iff (reset)
                                   !(ibus.req.mem_valid && pend_i_q));
  a_dbus_overrun: assert property (@(posedge clock) disable iff (reset)
                                   !(dbus.req.mem_valid && pend_d_q));

endmodule
